// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } rx_timer_state_t;

    localparam int USB_CLKS_PER_BIT = 8;
    localparam int USB_MAX_RUN_BITS = 7;

endpackage

// File: rtl/flex_counter.sv
// Up-counter 0..rollover_val with synchronous clear and a same-cycle
// rollover flag raised on the enabled count that wraps back to zero.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    wrap;

    assign wrap = count_q == rollover_val;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = count_enable & ~clear & wrap;

endmodule

// File: rtl/usb_rx_timer.sv
// USB full-speed bit-timing recovery: re-phases a local bit clock on each
// line edge, strobes mid-bit, counts bytes and flags over-long runs.
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = 4,
    parameter int MAX_RUN_BITS = USB_MAX_RUN_BITS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic d_edge,
    input  logic stuff_bit,
    output logic shift_enable,
    output logic byte_received,
    output logic bit_err
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(MAX_RUN_BITS + 1);

    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMP = PW'(SAMPLE_PHASE);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RUN_BITS);

    rx_timer_state_t state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [RW-1:0]   run_q, run_d;
    logic            strobe_q, strobe_d;
    logic            err_q, err_d;
    logic            byte_q, byte_d;
    logic [2:0]      bit_cnt;
    logic            bit_roll;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        run_d    = run_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
            run_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    phase_d = '0;
                    if (d_edge) begin
                        state_d = RUN;
                        phase_d = PH_ONE;
                    end
                end
                RUN: begin
                    if (d_edge) begin
                        phase_d = PH_ONE;
                    end else if (phase_q == PH_LAST) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // stuffed bits count toward the run length too
            if (strobe_q && run_q == RUN_MAX) begin
                err_d = 1'b1;
            end
            if (d_edge) begin
                run_d = '0;
            end else if (strobe_q && run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
            end
            strobe_d = (state_d == RUN) && (phase_d == PH_SAMP);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            run_q    <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            byte_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            run_q    <= run_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            byte_q   <= byte_d;
        end
    end

    assign shift_enable = strobe_q & ~stuff_bit;

    flex_counter #(
        .NUM_CNT_BITS(3)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (~enable),
        .count_enable (shift_enable),
        .rollover_val (3'd7),
        .count_out    (bit_cnt),
        .rollover_flag(bit_roll)
    );

    assign byte_d = enable & bit_roll & (bit_cnt == 3'd7);

    assign byte_received = byte_q;
    assign bit_err       = err_q;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Scoreboard bench for usb_rx_timer: stimulus queues expected event cycles,
// a negedge monitor pops and compares them as the DUT produces events.
module tb_usb_rx_timer;

    localparam int SP  = 4;
    localparam int CPB = 8;

    logic clk       = 1'b0;
    logic n_rst     = 1'b0;
    logic enable    = 1'b0;
    logic d_edge    = 1'b0;
    logic stuff_bit = 1'b0;
    logic shift_enable;
    logic byte_received;
    logic bit_err;

    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   exp_bits = 0;
    bit   exp_err  = 1'b0;
    logic prev_err = 1'b0;
    int   m_exp;
    int   c0;

    int q_se[$];
    int q_br[$];
    int q_er[$];

    usb_rx_timer #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_PHASE(SP),
        .MAX_RUN_BITS(7)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_err      (bit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_enable !== 1'b0) begin
                n_cmp++;
                if (q_se.size() == 0) begin
                    n_fail++;
                    $display("FAIL shift_enable: got strobe at cycle %0d, want none", cyc);
                end else begin
                    m_exp = q_se.pop_front();
                    if (m_exp != cyc) begin
                        n_fail++;
                        $display("FAIL shift_enable: got cycle %0d, want %0d", cyc, m_exp);
                    end
                end
            end
            if (byte_received !== 1'b0) begin
                n_cmp++;
                if (q_br.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_received: got pulse at cycle %0d, want none", cyc);
                end else begin
                    m_exp = q_br.pop_front();
                    if (m_exp != cyc) begin
                        n_fail++;
                        $display("FAIL byte_received: got cycle %0d, want %0d", cyc, m_exp);
                    end
                end
            end
            if (bit_err !== prev_err) begin
                n_cmp++;
                if (q_er.size() == 0) begin
                    n_fail++;
                    $display("FAIL bit_err: got change to %b at cycle %0d, want none", bit_err, cyc);
                end else begin
                    m_exp = q_er.pop_front();
                    if (m_exp != cyc) begin
                        n_fail++;
                        $display("FAIL bit_err: got change at cycle %0d, want %0d", cyc, m_exp);
                    end
                end
            end
        end
        prev_err = bit_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic push_shift(input int c);
        q_se.push_back(c);
        exp_bits++;
        if (exp_bits == 8) begin
            q_br.push_back(c + 1);
            exp_bits = 0;
        end
    endtask

    // one line transition, then gap cycles until the next one
    task automatic bit_edge(input int gap, input bit stuffed);
        int s;
        s = cyc;
        if (!stuffed) push_shift(s + SP);
        for (int i = 0; i < gap; i++) begin
            d_edge    = (i == 0);
            stuff_bit = stuffed && (i == SP);
            tick();
        end
        d_edge    = 1'b0;
        stuff_bit = 1'b0;
    endtask

    task automatic drop_enable();
        enable   = 1'b0;
        exp_bits = 0;
        if (exp_err) begin
            q_er.push_back(cyc + 1);
            exp_err = 1'b0;
        end
        tick();
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("reset shift_enable", shift_enable, 1'b0);
        chk("reset byte_received", byte_received, 1'b0);
        chk("reset bit_err", bit_err, 1'b0);
        n_rst = 1'b1;
        tick();

        // reset asserted mid-run at phase 5
        enable = 1'b1;
        c0     = cyc;
        q_se.push_back(c0 + SP);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        repeat (4) tick();
        n_rst = 1'b0;
        #1;
        chk("midrun rst shift_enable", shift_enable, 1'b0);
        chk("midrun rst byte_received", byte_received, 1'b0);
        chk("midrun rst bit_err", bit_err, 1'b0);
        tick();
        n_rst  = 1'b1;
        enable = 1'b0;

        // edges without enable, then enable without edges: silence
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (12) tick();

        // ideal byte
        repeat (8) bit_edge(8, 1'b0);
        drop_enable();

        // drift 7/9/8, then finish the byte
        bit_edge(7, 1'b0);
        bit_edge(9, 1'b0);
        bit_edge(8, 1'b0);
        repeat (5) bit_edge(8, 1'b0);
        drop_enable();

        // stuffed 7th of 9 strobes
        for (int i = 0; i < 9; i++) bit_edge(8, i == 6);
        drop_enable();

        // long run: single SYNC edge, then free-running strobes
        c0 = cyc;
        for (int k = 0; k < 9; k++) push_shift(c0 + SP + CPB * k);
        q_er.push_back(c0 + SP + CPB * 7 + 1);
        exp_err = 1'b1;
        d_edge  = 1'b1;
        tick();
        d_edge = 1'b0;
        repeat (69) tick();
        drop_enable();

        // abort after 5 bits, then a full fresh byte
        repeat (5) bit_edge(8, 1'b0);
        drop_enable();
        repeat (8) bit_edge(8, 1'b0);
        drop_enable();

        // edge coinciding with phase SAMPLE_PHASE-1
        c0     = cyc;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        repeat (2) tick();
        push_shift(c0 + 3 + SP);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        repeat (6) tick();
        drop_enable();
        repeat (4) tick();

        foreach (q_se[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL shift_enable missed: got none, want cycle %0d", q_se[i]);
        end
        foreach (q_br[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_received missed: got none, want cycle %0d", q_br[i]);
        end
        foreach (q_er[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bit_err missed: got no change, want cycle %0d", q_er[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
